// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the button event unit.
// Pure declarations: no logic, no latency, no backpressure.
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_HELD    = 2'd2
  } btn_state_e;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debouncer and press/long/repeat event FSM.
// Latency: press/release pulse DEBOUNCE_CYCLES+2 edges after first sample; no backpressure.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  // One counter serves both the long-press and the repeat interval.
  localparam int HOLD_W = max_int(cnt_width(LONG_CYCLES), cnt_width(REPEAT_CYCLES));

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              sync1_q, sync2_q;
  logic              level_q, level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  btn_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST = HOLD_W'(REPEAT_CYCLES - 1);
  logic repeat_q, repeat_d;
`endif

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Release is checked first so a long/repeat due on the same edge is dropped.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_d   = 1'b0;
`endif
    case (state_q)
      BTN_IDLE: begin
        if (level_q) begin
          state_d    = BTN_PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      BTN_PRESSED: begin
        if (!level_q) begin
          state_d    = BTN_IDLE;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d    = BTN_HELD;
          long_d     = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      BTN_HELD: begin
        if (!level_q) begin
          state_d    = BTN_IDLE;
          release_d  = 1'b1;
          hold_cnt_d = '0;
`ifdef BTN_AUTOREPEAT_EN
        end else if (hold_cnt_q == REP_LAST) begin
          repeat_d   = 1'b1;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end
      end
      default: begin
        state_d    = BTN_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= BTN_IDLE;
      hold_cnt_q <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end
  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_event_unit.sv
// NUM_BTN independent debounced button channels; auto-repeat enabled by BTN_AUTOREPEAT_EN.
// Latency: events DEBOUNCE_CYCLES+2 edges after first raw sample; no backpressure.
module button_event_unit #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] buttons,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat
);

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw_i (buttons[gi]),
      .level_o   (btn_level[gi]),
      .press_o   (btn_press[gi]),
      .release_o (btn_release[gi]),
      .long_o    (btn_long[gi]),
      .repeat_o  (btn_repeat[gi])
    );
  end

endmodule

// File: tb/tb_button_event_unit.sv
// Bench for button_event_unit: scenario table, hand-written corner sequences,
// and random stimulus checked every cycle against a cycle-indexed reference model.
module tb_button_event_unit;

  localparam int N = 5;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] buttons = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

  button_event_unit #(
    .NUM_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: per-edge history of raw samples and debounced levels.
  // A level flips once the last D synchronised samples all disagree with it;
  // events follow from level edges and the age of the hold since press.
  int           k_cyc = 0;
  int           rst_edge = 0;
  bit           model_live = 1'b0;
  logic [N-1:0] raw_at [int];
  logic [N-1:0] lvl_at [int];
  int           press_edge [N];
  logic [N-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0, e_repeat = '0;

  function automatic logic raw_eff(input int j, input int c);
    if (j <= rst_edge) return 1'b0;
    return raw_at[j][c];
  endfunction

  function automatic logic lvl_eff(input int j, input int c);
    if (j <= rst_edge) return 1'b0;
    return lvl_at[j][c];
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] nl;
    logic lv, all_diff, p1, p2;
    int age;
    k_cyc++;
    raw_at[k_cyc] = buttons;
    if (!rst_n) begin
      rst_edge   = k_cyc;
      lvl_at[k_cyc] = '0;
      e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      for (int c = 0; c < N; c++) begin
        lv = lvl_eff(k_cyc - 1, c);
        all_diff = (k_cyc - D + 1 > rst_edge);
        for (int j = 0; j < D; j++)
          if (raw_eff(k_cyc - j - 2, c) == lv) all_diff = 1'b0;
        nl[c] = all_diff ? ~lv : lv;
        p1 = lvl_eff(k_cyc - 1, c);
        p2 = lvl_eff(k_cyc - 2, c);
        e_press[c]   = p1 & ~p2;
        e_release[c] = ~p1 & p2;
        if (e_press[c]) press_edge[c] = k_cyc;
        age = k_cyc - press_edge[c];
        e_long[c]   = p1 & p2 & (age == L);
        e_repeat[c] = REP_ON & p1 & p2 & (age > L) & (((age - L) % R) == 0);
      end
      lvl_at[k_cyc] = nl;
      e_level = nl;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_level",   btn_level,   e_level);
      check("model_press",   btn_press,   e_press);
      check("model_release", btn_release, e_release);
      check("model_long",    btn_long,    e_long);
      check("model_repeat",  btn_repeat,  e_repeat);
      check("press_and_release_overlap", btn_press & btn_release, 0);
    end
  end

  // Scenario table: a single pulse of `hi` cycles on channel `ch`; offsets are
  // edges after the first high sample, -1 meaning the event never occurs.
  typedef struct {
    int ch; int hi;
    int n_press; int press_off;
    int n_rel;   int rel_off;
    int n_long;  int long_off;
    int n_rep;   int rep_off;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int idx, input vec_t v);
    int np = 0, nr = 0, nlg = 0, nrp = 0;
    int po = -1, ro = -1, lo = -1, rpo = -1;
    int w = v.hi + 24;
    string tag;
    for (int i = 0; i <= w; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (btn_press[v.ch])   begin np++;  if (po  < 0) po  = i - 1; end
        if (btn_release[v.ch]) begin nr++;  if (ro  < 0) ro  = i - 1; end
        if (btn_long[v.ch])    begin nlg++; if (lo  < 0) lo  = i - 1; end
        if (btn_repeat[v.ch])  begin nrp++; if (rpo < 0) rpo = i - 1; end
      end
      buttons[v.ch] = (i < v.hi);
    end
    tag = $sformatf("vec%0d", idx);
    check({tag, "_n_press"},   np,  v.n_press);
    check({tag, "_press_off"}, po,  v.press_off);
    check({tag, "_n_release"}, nr,  v.n_rel);
    check({tag, "_rel_off"},   ro,  v.rel_off);
    check({tag, "_n_long"},    nlg, v.n_long);
    check({tag, "_long_off"},  lo,  v.long_off);
    check({tag, "_n_repeat"},  nrp, v.n_rep);
    check({tag, "_rep_off"},   rpo, v.rep_off);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int np, po, nr, p2o, nz_press, any_rst;
    logic [N-1:0] press6, level6;

    vecs[0] = '{ch:0, hi:15, n_press:1, press_off:6, n_rel:1, rel_off:21, n_long:0, long_off:-1, n_rep:0, rep_off:-1};
    vecs[1] = '{ch:3, hi:3,  n_press:0, press_off:-1, n_rel:0, rel_off:-1, n_long:0, long_off:-1, n_rep:0, rep_off:-1};
    vecs[2] = '{ch:1, hi:4,  n_press:1, press_off:6, n_rel:1, rel_off:10, n_long:0, long_off:-1, n_rep:0, rep_off:-1};
    vecs[3] = '{ch:2, hi:20, n_press:1, press_off:6, n_rel:1, rel_off:26, n_long:0, long_off:-1, n_rep:0, rep_off:-1};
    vecs[4] = '{ch:2, hi:21, n_press:1, press_off:6, n_rel:1, rel_off:27, n_long:1, long_off:26, n_rep:0, rep_off:-1};
    vecs[5] = '{ch:2, hi:60, n_press:1, press_off:6, n_rel:1, rel_off:66, n_long:1, long_off:26,
                n_rep:(REP_ON ? 4 : 0), rep_off:(REP_ON ? 34 : -1)};
    vecs[6] = '{ch:4, hi:28, n_press:1, press_off:6, n_rel:1, rel_off:34, n_long:1, long_off:26, n_rep:0, rep_off:-1};

    rst_n = 1'b0;
    buttons = '0;
    repeat (3) @(negedge clk);
    check("reset_level",   btn_level,   0);
    check("reset_press",   btn_press,   0);
    check("reset_release", btn_release, 0);
    check("reset_long",    btn_long,    0);
    check("reset_repeat",  btn_repeat,  0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Bounce on channel 1: 2-cycle pulses, final rise at i=12.
    np = 0; po = -1; nr = 0;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (btn_press[1]) begin np++; if (po < 0) po = i - 1; end
        if (btn_release[1]) nr++;
      end
      buttons[1] = (i < 12) ? ((i % 4) < 2) : 1'b1;
    end
    check("bounce_n_press",   np, 1);
    check("bounce_press_off", po, 18);
    check("bounce_n_release", nr, 0);
    buttons[1] = 1'b0;
    repeat (14) @(negedge clk);

    // Simultaneous press on channels 1 and 3.
    nz_press = 0; press6 = '0; level6 = '0;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (btn_press != '0) nz_press++;
        if (i - 1 == 6) begin press6 = btn_press; level6 = btn_level; end
      end
      buttons = 5'b01010;
    end
    check("simul_press",        press6, 5'b01010);
    check("simul_level",        level6, 5'b01010);
    check("simul_press_cycles", nz_press, 1);
    buttons = '0;
    repeat (14) @(negedge clk);

    // Reset for two edges at press+10 while channel 4 is held.
    np = 0; po = -1; p2o = -1; nr = 0; any_rst = 0;
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (btn_press[4]) begin
          np++;
          if (po < 0) po = i - 1; else if (p2o < 0) p2o = i - 1;
        end
        if (btn_release[4]) nr++;
        if ((i - 1 == 16 || i - 1 == 17) &&
            ((btn_level | btn_press | btn_release | btn_long | btn_repeat) != '0)) any_rst++;
      end
      buttons[4] = 1'b1;
      rst_n = !(i == 16 || i == 17);
    end
    check("rst_hold_n_press",     np, 2);
    check("rst_hold_press_off",   po, 6);
    check("rst_hold_repress_off", p2o, 24);
    check("rst_hold_n_release",   nr, 0);
    check("rst_hold_outputs_zero", any_rst, 0);
    buttons = '0;
    repeat (30) @(negedge clk);

    // Random stimulus with occasional short resets; the model checks each cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        int thr;
        thr = (c == 2) ? 1 : ((c == 4) ? 2 : 6);
        if ($urandom_range(0, 99) < thr) buttons[c] = ~buttons[c];
      end
      rst_n = ($urandom_range(0, 799) != 0);
    end
    rst_n = 1'b1;
    buttons = '0;
    repeat (40) @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
